lfsr_stream_decrypt: RTL and testbench
======================================

// Module: lfsr_stream_decrypt
// PURPOSE
//  Receive side of the PUF-path LFSR stream cipher: recovers a plaintext block from a ciphertext block and a 32-bit seed.
//  Regenerates the transmit-side keystream from the same seed and XORs it out, BITS_PER_CYCLE bits per clock.
//  Sits between the ciphertext source (valid/ready in) and the key/response consumer (valid/ready out).
// PARAMETERS
//  LFSR_WIDTH      32            keystream register width; only 32 supported
//  TAP_MASK        32'h80200003  feedback taps (bits 31,21,1,0)
//  BLOCK_BITS      256           block size in bits
//  BITS_PER_CYCLE  1             keystream bits per RUN cycle; one of 1,2,4,8; must divide BLOCK_BITS
// PORTS
//  i_Clk          in   1           clock, rising edge
//  i_Reset        in   1           reset, synchronous, active-high
//  i_Enable       in   1           clock enable; low = all state frozen (reset still acts)
//  i_In_Valid     in   1           seed + ciphertext present
//  o_In_Ready     out  1           block can be accepted (IDLE)
//  i_Seed         in   LFSR_WIDTH  keystream seed
//  i_Cipher       in   BLOCK_BITS  ciphertext; bit i = stream bit i
//  o_Out_Valid    out  1           plaintext valid, held until taken
//  i_Out_Ready    in   1           consumer accepts plaintext
//  o_Plain        out  BLOCK_BITS  recovered plaintext
//  o_Busy         out  1           high in RUN
//  o_Err          out  1           one-cycle pulse, rejected seed (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; o_Plain=0, o_Out_Valid=0, o_Busy=0, o_Err=0, LFSR=0, count=0; o_In_Ready=1 after reset.
//  Keystream: s0=seed; fb(s)=~^(s & TAP_MASK); s(k+1)={s(k)[30:0],fb(s(k))}; k_i=s(i)[0]. o_Plain[i]=i_Cipher[i]^k_i.
//  FSM IDLE -> RUN -> HOLD -> IDLE; all transitions/updates only on edges with i_Enable=1.
//  IDLE: o_In_Ready=1. Accept on i_In_Valid&&o_In_Ready: latch seed into LFSR, i_Cipher into internal buffer, count=0 -> RUN.
//  i_Cipher/i_Seed may change freely after the accepting edge.
//  RUN: o_In_Ready=0, o_Busy=1. Per enabled edge: write o_Plain bits [count*BPC +: BPC] using next BPC keystream bits;
//   LFSR advances BPC steps; count++. Edge processing last chunk (count=BLOCK_BITS/BPC-1) -> HOLD, o_Out_Valid<=1.
//  Latency: o_Out_Valid rises on the (BLOCK_BITS/BPC)th enabled edge after the accepting edge (8 for BLOCK_BITS=8,BPC=1).
//  HOLD: o_Out_Valid=1, o_Plain stable. Edge with i_Out_Ready=1 -> IDLE, o_Out_Valid<=0; o_Plain keeps value.
//  No bypass: new block cannot be accepted on the same edge the output is taken; o_In_Ready rises next cycle.
//  i_In_Valid ignored outside IDLE; i_Out_Ready ignored outside HOLD.
//  i_Enable low: FSM, count, LFSR, outputs frozen; handshakes not honoured (no accept/take).
//  Reset mid-RUN or mid-HOLD: block discarded, all outputs to reset values next edge; reset wins over all events.
//  count width $clog2(BLOCK_BITS/BPC)+1; no wrap inside a block.
//  Seed all-ones is the XNOR lock-up state (keystream constant 1); handling per CONFIGURATION.
// CONFIGURATION
//  Macro LFSR_DEC_LOCKUP_CHECK_EN:
//   defined: accept with i_Seed==32'hFFFFFFFF consumes the block, stays IDLE, pulses o_Err for one cycle, no o_Out_Valid.
//   undefined: all-ones seed processed normally (plaintext = ~ciphertext); o_Err tied 0.
// TESTING
//  (all with BLOCK_BITS=8, BPC=1 unless noted)
//  T1 seed=0, cipher=8'h00 -> o_Out_Valid on 8th edge after accept, o_Plain=8'h92.
//  T2 seed=0, cipher=8'hFF -> o_Plain=8'h6D; BPC=2 and BPC=4 builds give same values at 4 and 2 edges.
//  T3 i_Out_Ready low 5 cycles in HOLD -> o_Out_Valid/o_Plain stable; i_Out_Ready=1 -> IDLE, o_In_Ready=1 next cycle.
//  T4 i_Reset at 3rd RUN edge -> all outputs reset next edge; new block seed=0,cipher=0 then gives 8'h92.
//  T5 i_Enable low 4 cycles mid-RUN -> latency grows by exactly 4, o_Plain still 8'h92.
//  T6 seed=32'hFFFFFFFF, cipher=8'h0F: with macro -> one o_Err pulse, no o_Out_Valid; without -> o_Plain=8'hF0.
//  Default build: random seeds/blocks, encrypt with golden model, decrypt -> plaintext round-trips bit-exact.

Source files
------------

// File: rtl/lfsr_stream_decrypt.sv
// Receive-side LFSR stream cipher: regenerates the keystream from a 32-bit seed and XORs it out of a ciphertext block.
// Optional all-ones seed rejection is enabled by defining LFSR_DEC_LOCKUP_CHECK_EN.
module lfsr_stream_decrypt #(
  parameter int                    LFSR_WIDTH     = 32,
  parameter logic [LFSR_WIDTH-1:0] TAP_MASK       = 32'h80200003,
  parameter int                    BLOCK_BITS     = 256,
  parameter int                    BITS_PER_CYCLE = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Enable,
  input  logic                  i_In_Valid,
  output logic                  o_In_Ready,
  input  logic [LFSR_WIDTH-1:0] i_Seed,
  input  logic [BLOCK_BITS-1:0] i_Cipher,
  output logic                  o_Out_Valid,
  input  logic                  i_Out_Ready,
  output logic [BLOCK_BITS-1:0] o_Plain,
  output logic                  o_Busy,
  output logic                  o_Err
);

  localparam int NCHUNK = BLOCK_BITS / BITS_PER_CYCLE;
  localparam int CW     = $clog2(NCHUNK) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]                state_q;
  logic [LFSR_WIDTH-1:0]     lfsr_q, lfsr_d;
  logic [BLOCK_BITS-1:0]     cipher_q;
  logic [BLOCK_BITS-1:0]     plain_q, plain_d;
  logic [CW-1:0]             count_q;
  logic [BITS_PER_CYCLE-1:0] ks;
  logic                      err_q;
  logic                      seed_lockup;
  logic                      last_chunk;

`ifdef LFSR_DEC_LOCKUP_CHECK_EN
  assign seed_lockup = (i_Seed == {LFSR_WIDTH{1'b1}});
`else
  assign seed_lockup = 1'b0;
`endif

  // Unroll BITS_PER_CYCLE XNOR-feedback steps; ks[b] is the low bit before step b.
  always_comb begin : keystream_steps
    logic [LFSR_WIDTH-1:0] s;
    s  = lfsr_q;
    ks = '0;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      ks[b] = s[0];
      s     = {s[LFSR_WIDTH-2:0], ~^(s & TAP_MASK)};
    end
    lfsr_d = s;
  end

  always_comb begin
    plain_d = plain_q;
    for (int c = 0; c < NCHUNK; c++) begin
      if (count_q == CW'(c)) begin
        plain_d[c*BITS_PER_CYCLE +: BITS_PER_CYCLE] =
          cipher_q[c*BITS_PER_CYCLE +: BITS_PER_CYCLE] ^ ks;
      end
    end
  end

  assign last_chunk = (count_q == CW'(NCHUNK - 1));

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= '0;
      cipher_q <= '0;
      plain_q  <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // The error flag is a single-cycle pulse even if the enable drops right after.
      err_q <= 1'b0;
      if (i_Enable) begin
        case (state_q)
          ST_IDLE: begin
            if (i_In_Valid) begin
              if (seed_lockup) begin
                err_q <= 1'b1;
              end else begin
                lfsr_q   <= i_Seed;
                cipher_q <= i_Cipher;
                count_q  <= '0;
                state_q  <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            plain_q <= plain_d;
            lfsr_q  <= lfsr_d;
            count_q <= count_q + 1'b1;
            if (last_chunk) state_q <= ST_HOLD;
          end
          ST_HOLD: begin
            if (i_Out_Ready) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_In_Ready  = (state_q == ST_IDLE);
  assign o_Busy      = (state_q == ST_RUN);
  assign o_Out_Valid = (state_q == ST_HOLD);
  assign o_Plain     = plain_q;
  assign o_Err       = err_q;

endmodule

// File: tb/tb_lfsr_stream_decrypt.sv
// Bench for lfsr_stream_decrypt: fixed vectors, handshake/reset/enable corner cases, and randomized round-trips
// against a keystream model, on an 8-bit/1-bit-per-cycle instance and a 16-bit/4-bit-per-cycle instance.
module tb_lfsr_stream_decrypt;
  localparam int          BB  = 8;
  localparam int          BB4 = 16;
  localparam logic [31:0] TAP = 32'h80200003;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en;
  logic          in_valid, out_ready, in_ready, out_valid, busy, err;
  logic [31:0]   seed;
  logic [BB-1:0] cipher, plain;

  logic           in_valid4, out_ready4, in_ready4, out_valid4, busy4, err4;
  logic [31:0]    seed4;
  logic [BB4-1:0] cipher4, plain4;

  int checks = 0;
  int errors = 0;

  lfsr_stream_decrypt #(.LFSR_WIDTH(32), .BLOCK_BITS(BB), .BITS_PER_CYCLE(1)) u_dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en),
    .i_In_Valid(in_valid), .o_In_Ready(in_ready), .i_Seed(seed), .i_Cipher(cipher),
    .o_Out_Valid(out_valid), .i_Out_Ready(out_ready), .o_Plain(plain),
    .o_Busy(busy), .o_Err(err)
  );

  lfsr_stream_decrypt #(.LFSR_WIDTH(32), .BLOCK_BITS(BB4), .BITS_PER_CYCLE(4)) u_dut4 (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en),
    .i_In_Valid(in_valid4), .o_In_Ready(in_ready4), .i_Seed(seed4), .i_Cipher(cipher4),
    .o_Out_Valid(out_valid4), .i_Out_Ready(out_ready4), .o_Plain(plain4),
    .o_Busy(busy4), .o_Err(err4)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Keystream model: bit i is the LSB of the i-th state; feedback is 1 when the tapped bits have even parity.
  function automatic logic [63:0] keystream(input logic [31:0] s0, input int n);
    logic [31:0] s;
    logic [63:0] k;
    s = s0;
    k = '0;
    for (int i = 0; i < n; i++) begin
      k[i] = s[0];
      s = (s << 1) | (($countones(s & TAP) % 2 == 0) ? 32'd1 : 32'd0);
    end
    return k;
  endfunction

  task automatic send(input logic [31:0] s, input logic [BB-1:0] c);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", in_ready, 1);
    in_valid = 1'b1; seed = s; cipher = c;
    @(posedge clk); #1;
    in_valid = 1'b0; seed = $urandom; cipher = BB'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("take_valid", out_valid, 0);
    check("take_ready", in_ready, 1);
  endtask

  typedef struct {
    logic [31:0]   seed;
    logic [BB-1:0] cipher;
    logic [BB-1:0] plain;
    int            lat;
  } vec_t;

  vec_t vt[5];

  initial begin
    int          lat;
    bit          stable;
    logic [63:0] k;
    logic [31:0] s;
    logic [BB4-1:0] p;

    vt[0] = '{32'd0, 8'h00, 8'h92, 8};
    vt[1] = '{32'd0, 8'hFF, 8'h6D, 8};
    vt[2] = '{32'd0, 8'h92, 8'h00, 8};
    vt[3] = '{32'd0, 8'hA5, 8'h37, 8};
    vt[4] = '{32'd1, 8'h00, 8'h49, 8};

    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; seed = '0; cipher = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; seed4 = '0; cipher4 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_plain", plain, 0);
    check("rst_ready", in_ready, 1);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      send(vt[i].seed, vt[i].cipher);
      check("vec_busy", busy, 1);
      check("vec_ready_run", in_ready, 0);
      wait_valid(lat);
      check("vec_lat", lat, vt[i].lat);
      check("vec_plain", plain, vt[i].plain);
      check("vec_ready_hold", in_ready, 0);
      check("vec_busy_hold", busy, 0);
      $display("vec %0d seed=%08h cipher=%02h plain=%02h lat=%0d", i, vt[i].seed, vt[i].cipher, plain, lat);
      take();
    end

    // Hold with consumer stalled, new input offered during hold and on the take edge.
    send(32'd0, 8'h00);
    wait_valid(lat);
    stable = 1'b1;
    in_valid = 1'b1; seed = 32'd1; cipher = 8'h55;
    repeat (5) begin
      @(posedge clk); #1;
      if (!out_valid || plain !== 8'h92) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    take();
    check("no_bypass_busy", busy, 0);
    in_valid = 1'b0;
    check("hold_plain_kept", plain, 8'h92);
    $display("hold-stall seed=00000000 plain=%02h", plain);

    // Reset on the third RUN edge.
    send(32'd0, 8'h00);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_plain", plain, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_ready", in_ready, 1);
    send(32'd0, 8'h00);
    wait_valid(lat);
    check("post_rst_lat", lat, 8);
    check("post_rst_plain", plain, 8'h92);
    $display("reset-recover plain=%02h lat=%0d", plain, lat);
    take();

    // Enable low for 4 cycles mid-RUN, then low during a take attempt.
    send(32'd0, 8'h00);
    repeat (2) begin @(posedge clk); #1; end
    en = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("en_low_busy", busy, 1);
    check("en_low_valid", out_valid, 0);
    en = 1'b1;
    wait_valid(lat);
    check("en_low_lat", lat + 6, 12);
    check("en_low_plain", plain, 8'h92);
    en = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("en_low_hold", out_valid, 1);
    en = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("en_take_valid", out_valid, 0);
    check("en_take_ready", in_ready, 1);
    $display("enable-stall plain=%02h lat=%0d", plain, lat + 6);

    // All-ones seed.
    send(32'hFFFFFFFF, 8'h0F);
`ifdef LFSR_DEC_LOCKUP_CHECK_EN
    check("lock_err", err, 1);
    check("lock_busy", busy, 0);
    @(posedge clk); #1;
    check("lock_err_pulse", err, 0);
    lat = 0;
    while (!out_valid && lat < 12) begin @(posedge clk); #1; lat++; end
    check("lock_no_valid", out_valid, 0);
    $display("lockup seed=ffffffff err pulsed");
`else
    check("lock_err", err, 0);
    wait_valid(lat);
    check("lock_lat", lat, 8);
    check("lock_plain", plain, 8'hF0);
    $display("lockup seed=ffffffff plain=%02h", plain);
    take();
`endif

    // Random round-trips, with ignored handshakes toggling during RUN.
    for (int i = 0; i < 20; i++) begin
      p = BB4'($urandom);
      s = $urandom;
      if (s == 32'hFFFFFFFF) s = 32'h0;
      k = keystream(s, BB);
      send(s, p[BB-1:0] ^ k[BB-1:0]);
      in_valid = 1'($urandom); seed = $urandom; out_ready = 1'($urandom);
      wait_valid(lat);
      in_valid = 1'b0; out_ready = 1'b0;
      check("rnd_lat", lat, 8);
      check("rnd_plain", plain, p[BB-1:0]);
      $display("rnd %0d seed=%08h plain=%02h exp=%02h", i, s, plain, p[BB-1:0]);
      take();
    end

    // Four bits per cycle: fixed seed 0 then random round-trips.
    for (int i = 0; i < 12; i++) begin
      p = BB4'($urandom);
      s = (i == 0) ? 32'd0 : $urandom;
      if (s == 32'hFFFFFFFF) s = 32'h0;
      if (i == 0) p = '0;
      k = keystream(s, BB4);
      in_valid4 = 1'b1; seed4 = s; cipher4 = p ^ k[BB4-1:0];
      @(posedge clk); #1;
      in_valid4 = 1'b0; cipher4 = BB4'($urandom);
      check("bpc4_busy", busy4, 1);
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!out_valid4 && lat < 100);
      check("bpc4_lat", lat, 4);
      check("bpc4_plain", plain4, p);
      if (i == 0) check("bpc4_seed0_low", plain4[7:0] ^ k[7:0], 8'h92);
      $display("bpc4 %0d seed=%08h plain=%04h exp=%04h lat=%0d", i, s, plain4, p, lat);
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
      check("bpc4_take", out_valid4, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
